reg_rename_unit: RTL
====================

// Module: reg_rename_unit
// PURPOSE
//  Parametrised rename stage between decode and ROB/issue queue/LSQ. Owns the speculative map table
//  (RAT), the retirement map (RRAT) and an in-order circular free list. Renames one instruction per
//  cycle through a valid/ready handshake. On FLUSH it restores the RAT and free list from committed state.
// PARAMETERS
//  ARCH_REGS  32  architectural registers; AW = $clog2(ARCH_REGS)
//  PHYS_REGS  64  physical registers, > ARCH_REGS; PW = $clog2(PHYS_REGS)
//  PC_W       32  width of instruction word and PC
//  CTRL_W     7   width of decoder control bundle (passed through unchanged)
// PORTS
//  CLK          in   1       clock, rising edge
//  RESET        in   1       reset, asynchronous, active-low
//  STALL        in   1       global stall: hold output register, accept nothing
//  FLUSH        in   1       mispredict/exception: drop in-flight rename, restore committed state
//  in_valid     in   1       decoded instruction present
//  in_ready     out  1       rename accepts this cycle
//  in_instr     in   PC_W    instruction word
//  in_pc        in   PC_W    instruction PC
//  in_ctrl      in   CTRL_W  control bundle
//  in_rs,in_rt  in   AW      source architectural regs
//  in_rd        in   AW      destination architectural reg
//  in_wr        in   1       instruction writes in_rd (loads included)
//  in_ld,in_st  in   1       load / store
//  out_valid    out  1       renamed entry valid
//  out_ready    in   1       ROB, IQ and LSQ can all take the entry
//  out_instr,out_pc,out_ctrl  out  PC_W,PC_W,CTRL_W  registered copies
//  out_prs,out_prt  out  PW  physical sources
//  out_pdst     out  PW      new physical destination (0 if no allocation)
//  out_pold     out  PW      previous mapping of in_rd; ROB returns it on commit
//  out_alloc    out  1       entry allocated a physical reg
//  out_to_iq    out  1       !ld & !st
//  out_to_lsq   out  1       ld | st
//  commit_valid in   1       ROB retires an entry that allocated (in program order)
//  commit_ard   in   AW      its architectural destination
//  commit_pdst  in   PW      its physical destination
//  commit_pold  in   PW      physical reg to return to the free list
//  free_count   out  PW+1    free-list occupancy available for allocation
// BEHAVIOUR
//  - Reset: RAT[i]=RRAT[i]=i; free list holds ARCH_REGS..PHYS_REGS-1 ascending; head=chead=tail=0;
//    free_count=PHYS_REGS-ARCH_REGS; all out_* = 0; out_valid=0.
//  - need = in_wr & (in_rd!=0). Arch reg 0 is never renamed: pdst=0, out_alloc=0, no dequeue.
//  - in_ready = !STALL & !FLUSH & (!out_valid | out_ready) & (!need | free_count!=0). Combinational.
//  - Accept (in_valid & in_ready): next edge latches the out_* fields and sets out_valid=1. Sources come
//    from the pre-update RAT. pold=RAT[in_rd]. If need: pdst=fl[head], head++, RAT[in_rd]<=pdst.
//    Latency: 1 cycle.
//  - If out_valid & out_ready & no accept: out_valid<=0. STALL freezes out_* and out_valid regardless of out_ready.
//  - Commit: RRAT[commit_ard]<=commit_pdst; fl[tail]<=commit_pold; tail++, chead++. Processed even
//    during STALL or FLUSH.
//  - Ring depth D=PHYS_REGS-ARCH_REGS. Pointers wrap modulo D. tail-chead == D always, so the ring
//    never overflows. free_count = D-(head-chead) mod D, held in a separate counter.
//  - Same-cycle accept+commit: dequeue and enqueue both happen and free_count is unchanged. A reg freed in
//    cycle N is allocatable from cycle N+1 (in_ready uses the registered count).
//  - FLUSH, highest priority over accept: RAT<=RRAT including a same-cycle commit write;
//    head<=chead (post-commit); free_count<=D; out_valid<=0. Flush and commit on the same edge apply
//    commit first.
//  - RESET asserted mid-operation returns all state to reset values immediately.
// CONFIGURATION
//  RENAME_BUSY_EN defined: adds ports wb_valid in 1, wb_preg in PW, busy out PHYS_REGS.
//   - Accept with need sets busy[pdst].
//   - wb_valid clears busy[wb_preg]. If wb_preg equals pdst being set on the same edge, set wins.
//   - Adds out_rs_busy and out_rt_busy (out 1). Each is the busy bit of its source at rename time, with
//     same-cycle wb bypass.
//   - Reset and FLUSH clear all busy bits. busy[0] stays 0.
//  Not defined: these ports and all busy logic are absent.
// TESTING
//  - Reset, then rename add r3<-r1,r2 -> out_prs=1, out_prt=2, out_pdst=32, out_pold=3; free_count 31.
//  - Back-to-back writes to r3 -> second has out_pold=32, out_pdst=33. A reader of r3 gets prs=33.
//  - 32 allocating renames with no commit -> free_count=0, in_ready=0. One commit of pold=3 ->
//    in_ready=1 next cycle; the next alloc gets pdst=3 after the ring wraps.
//  - Rename r5->32, r6->33; commit only the first; FLUSH -> RAT[5]=32, RAT[6]=6, free_count=32,
//    next alloc gets 33.
//  - in_rd=0 with in_wr=1 -> out_pdst=0, out_alloc=0, free_count unchanged. out_ready=0 for 3 cycles ->
//    out_* held and in_ready=0.
//  - RENAME_BUSY_EN: alloc pdst=32 -> busy[32]=1. wb_valid with wb_preg=32 -> 0. A dependent renamed in
//    the wb cycle sees out_rs_busy=0.

Source files
------------

// File: rtl/reg_rename_unit.sv
// Register rename stage: speculative map (RAT), retirement map (RRAT) and in-order circular free list.
// Latency: 1 cycle from accept to registered renamed entry; commits take effect on the next edge.
// Backpressure: in_ready drops on STALL, FLUSH, a full un-drained output register, or an empty free list.
// Optional feature macro: RENAME_BUSY_EN adds per-physical-register busy tracking with writeback bypass.
module reg_rename_unit #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int PC_W      = 32,
    parameter int CTRL_W    = 7,
    localparam int AW       = $clog2(ARCH_REGS),
    localparam int PW       = $clog2(PHYS_REGS)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [AW-1:0]     in_rs,
    input  logic [AW-1:0]     in_rt,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_wr,
    input  logic              in_ld,
    input  logic              in_st,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PW-1:0]     out_prs,
    output logic [PW-1:0]     out_prt,
    output logic [PW-1:0]     out_pdst,
    output logic [PW-1:0]     out_pold,
    output logic              out_alloc,
    output logic              out_to_iq,
    output logic              out_to_lsq,
    input  logic              commit_valid,
    input  logic [AW-1:0]     commit_ard,
    input  logic [PW-1:0]     commit_pdst,
    input  logic [PW-1:0]     commit_pold,
    output logic [PW:0]       free_count
`ifdef RENAME_BUSY_EN
    ,
    input  logic                 wb_valid,
    input  logic [PW-1:0]        wb_preg,
    output logic [PHYS_REGS-1:0] busy,
    output logic                 out_rs_busy,
    output logic                 out_rt_busy
`endif
);

    // Free-list ring depth; tail always trails chead by exactly D, so it can never overflow.
    localparam int D  = PHYS_REGS - ARCH_REGS;
    localparam int QW = (D > 1) ? $clog2(D) : 1;

    typedef struct packed {
        logic [PC_W-1:0]   instr;
        logic [PC_W-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic [PW-1:0]     prs;
        logic [PW-1:0]     prt;
        logic [PW-1:0]     pdst;
        logic [PW-1:0]     pold;
        logic              alloc;
        logic              to_iq;
        logic              to_lsq;
`ifdef RENAME_BUSY_EN
        logic              rs_busy;
        logic              rt_busy;
`endif
    } out_t;

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        return (p == QW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [PW-1:0] rat_q  [ARCH_REGS];
    logic [PW-1:0] rat_d  [ARCH_REGS];
    logic [PW-1:0] rrat_q [ARCH_REGS];
    logic [PW-1:0] rrat_d [ARCH_REGS];
    logic [PW-1:0] fl_q   [D];

    logic [QW-1:0] head_q, head_d;
    logic [QW-1:0] chead_q, chead_d;
    logic [QW-1:0] tail_q, tail_d;
    logic [PW:0]   fc_q, fc_d;

    out_t out_q, out_d;
    logic vld_q, vld_d;

    logic          need;
    logic          acc;
    logic          alloc;
    logic [PW-1:0] new_preg;
    logic [PW-1:0] src_s;
    logic [PW-1:0] src_t;

    // Handshake: an allocating rename also needs a free register in the registered count.
    always_comb begin
        need     = in_wr & (in_rd != '0);
        in_ready = !STALL && !FLUSH && (!vld_q || out_ready) && (!need || (fc_q != '0));
        acc      = in_valid & in_ready;
        alloc    = acc & need;
        new_preg = fl_q[head_q];
        src_s    = rat_q[in_rs];
        src_t    = rat_q[in_rt];
    end

    // Retirement map next state: commit write (arch reg 0 is pinned to preg 0).
    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            rrat_d[i] = rrat_q[i];
        end
        if (commit_valid && (commit_ard != '0)) begin
            rrat_d[commit_ard] = commit_pdst;
        end
    end

    // Speculative map next state: flush copies the post-commit retirement map, else apply allocation.
    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            rat_d[i] = FLUSH ? rrat_d[i] : rat_q[i];
        end
        if (!FLUSH && alloc) begin
            rat_d[in_rd] = new_preg;
        end
    end

    // Pointer and free-count next state; commit is applied before flush rewinds head.
    always_comb begin
        chead_d = commit_valid ? ptr_inc(chead_q) : chead_q;
        tail_d  = commit_valid ? ptr_inc(tail_q) : tail_q;
        if (FLUSH) begin
            head_d = chead_d;
            fc_d   = (PW+1)'(D);
        end else begin
            head_d = alloc ? ptr_inc(head_q) : head_q;
            fc_d   = fc_q + (PW+1)'(commit_valid) - (PW+1)'(alloc);
        end
    end

`ifdef RENAME_BUSY_EN
    logic [PHYS_REGS-1:0] busy_q, busy_d;

    // Busy bits: writeback clears, allocation sets (set wins on collision), flush clears all.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_preg] = 1'b0;
        end
        if (alloc) begin
            busy_d[new_preg] = 1'b1;
        end
        if (FLUSH) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Busy state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`endif

    // Renamed entry assembled from the pre-update map.
    always_comb begin
        out_d        = '0;
        out_d.instr  = in_instr;
        out_d.pc     = in_pc;
        out_d.ctrl   = in_ctrl;
        out_d.prs    = src_s;
        out_d.prt    = src_t;
        out_d.pdst   = need ? new_preg : '0;
        out_d.pold   = rat_q[in_rd];
        out_d.alloc  = need;
        out_d.to_iq  = !in_ld && !in_st;
        out_d.to_lsq = in_ld || in_st;
`ifdef RENAME_BUSY_EN
        out_d.rs_busy = busy_q[src_s] && !(wb_valid && (wb_preg == src_s));
        out_d.rt_busy = busy_q[src_t] && !(wb_valid && (wb_preg == src_t));
`endif
    end

    // Output valid: flush drops the entry, stall freezes, accept loads, drain clears.
    always_comb begin
        vld_d = vld_q;
        if (FLUSH) begin
            vld_d = 1'b0;
        end else if (!STALL) begin
            if (acc) begin
                vld_d = 1'b1;
            end else if (out_ready) begin
                vld_d = 1'b0;
            end
        end
    end

    // Output register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            if (acc) begin
                out_q <= out_d;
            end
        end
    end

    // Map tables, pointers and free count.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_q[i]  <= PW'(i);
                rrat_q[i] <= PW'(i);
            end
            head_q  <= '0;
            chead_q <= '0;
            tail_q  <= '0;
            fc_q    <= (PW+1)'(D);
        end else begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_q[i]  <= rat_d[i];
                rrat_q[i] <= rrat_d[i];
            end
            head_q  <= head_d;
            chead_q <= chead_d;
            tail_q  <= tail_d;
            fc_q    <= fc_d;
        end
    end

    // Free-list storage: committed old mappings enter at the tail.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < D; i++) begin
                fl_q[i] <= PW'(ARCH_REGS + i);
            end
        end else if (commit_valid) begin
            fl_q[tail_q] <= commit_pold;
        end
    end

    assign free_count = fc_q;
    assign out_valid  = vld_q;
    assign out_instr  = out_q.instr;
    assign out_pc     = out_q.pc;
    assign out_ctrl   = out_q.ctrl;
    assign out_prs    = out_q.prs;
    assign out_prt    = out_q.prt;
    assign out_pdst   = out_q.pdst;
    assign out_pold   = out_q.pold;
    assign out_alloc  = out_q.alloc;
    assign out_to_iq  = out_q.to_iq;
    assign out_to_lsq = out_q.to_lsq;
`ifdef RENAME_BUSY_EN
    assign out_rs_busy = out_q.rs_busy;
    assign out_rt_busy = out_q.rt_busy;
`endif

endmodule
